// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constants and sync FSM state type
//
// Purpose : default 796x515 timing, frame totals, sync-start offsets,
//           lock/error thresholds and the decoder state encoding.
// Ports   : none (package).
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 56;
    localparam int VGA_H_SYNC    = 40;
    localparam int VGA_H_BP      = 60;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 0;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;

    localparam int VGA_LOCK_FRAMES = 2;
    localparam int VGA_ERR_LIMIT   = 3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_t;

    // Two full lines without an hsync rise means the source is gone.
    function automatic int wd_limit(input int h_total);
        return 2 * h_total;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - ticked rising-edge detector for one sync input
//
// Purpose : remembers the previous ticked sample of a sync line and flags
//           a rise on the tick where the line goes 0 -> 1.
// Ports   : clk, reset (async, active-high)
//           i_tick  - pixel tick; the history register only moves on ticks
//           i_sync  - sync input sample
//           o_rise  - high during the clk where a ticked rise is seen
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_sync,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else if (i_tick) begin
            r_prev <= i_sync;
        end
    end

    assign o_rise = i_tick & i_sync & ~r_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder with lock tracking
//
// Purpose : reconstructs pixel coordinates from hsync/vsync, checks sync
//           positions against the expected timing and tracks lock.
// Ports   : clk, reset (async, active-high)
//           pxl_en            - pixel tick qualifying every clk edge
//           hsync, vsync      - active-high incoming syncs
//           pxl_x, pxl_y      - coordinate of the most recent sample
//           video             - locked and inside the visible area
//           locked            - decoder in LOCKED state
//           frame_start       - pulse when locked counters reach (0,0)
//           sync_err          - pulse on timing mismatch or watchdog expiry
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter int ERR_LIMIT   = VGA_ERR_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pxl_en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pxl_x,
    output logic [9:0] pxl_y,
    output logic       video,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_LOAD   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  V_LOAD   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [10:0] WD_LIMIT = 11'(wd_limit(H_TOTAL));
    localparam logic [7:0]  GOOD_MAX = 8'(LOCK_FRAMES);
    localparam logic [7:0]  ERR_MAX  = 8'(ERR_LIMIT);

    sync_state_t r_state;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [10:0] r_wd;
    logic [7:0]  r_good_cnt;
    logic [7:0]  r_err_cnt;
    logic        r_video;
    logic        r_locked;
    logic        r_frame_start;
    logic        r_sync_err;

    logic        w_h_rise;
    logic        w_v_rise;
    logic        w_h_wrap;
    logic [9:0]  w_h_pred;
    logic [9:0]  w_v_pred;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic        w_h_mis;
    logic        w_v_mis;
    logic        w_mis;
    logic        w_pass;
    logic [10:0] w_wd_inc;
    logic        w_wd_sat;
    logic [10:0] w_wd_next;
    logic        w_wd_expire;
    logic        w_video_next;
    logic        w_origin;

    vga_sync_edge u_hs_edge (
        .clk    (clk),
        .reset  (reset),
        .i_tick (pxl_en),
        .i_sync (hsync),
        .o_rise (w_h_rise)
    );

    vga_sync_edge u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .i_tick (pxl_en),
        .i_sync (vsync),
        .o_rise (w_v_rise)
    );

    // Free-running prediction; the sync checks compare against where the
    // counters would be had no sync arrived.
    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_h_pred = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    assign w_v_pred = !w_h_wrap ? r_v_cnt :
                      (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;

    // vsync realigns the whole raster, so its h load overrides hsync's.
    assign w_h_next = w_v_rise ? 10'd0 : (w_h_rise ? H_LOAD : w_h_pred);
    assign w_v_next = w_v_rise ? V_LOAD : w_v_pred;

    // A simultaneous h and v mismatch is one error event.
    assign w_h_mis = w_h_rise && (w_h_pred != H_LOAD);
    assign w_v_mis = w_v_rise && (w_v_pred != V_LOAD);
    assign w_mis   = w_h_mis | w_v_mis;
    assign w_pass  = (w_h_rise | w_v_rise) & ~w_mis;

    assign w_wd_inc    = r_wd + 11'd1;
    assign w_wd_sat    = &r_wd;
    assign w_wd_next   = w_h_rise ? 11'd0 : (w_wd_sat ? r_wd : w_wd_inc);
    assign w_wd_expire = ~w_h_rise & ~w_wd_sat & (w_wd_inc == WD_LIMIT);

    assign w_video_next = (w_h_next < H_VIS) && (w_v_next < V_VIS);
    assign w_origin     = (w_h_next == 10'd0) && (w_v_next == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_SEARCH;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_wd          <= 11'd0;
            r_good_cnt    <= 8'd0;
            r_err_cnt     <= 8'd0;
            r_video       <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            if (pxl_en) begin
                r_h_cnt <= w_h_next;
                r_v_cnt <= w_v_next;
                r_wd    <= w_wd_next;
                if (w_wd_expire) begin
                    r_state    <= ST_SEARCH;
                    r_good_cnt <= 8'd0;
                    r_err_cnt  <= 8'd0;
                    r_locked   <= 1'b0;
                    r_video    <= 1'b0;
                    r_sync_err <= 1'b1;
                end else begin
                    case (r_state)
                        ST_SEARCH: begin
                            if (w_v_rise) begin
                                r_state    <= ST_VERIFY;
                                r_good_cnt <= 8'd0;
                            end
                        end
                        ST_VERIFY: begin
                            if (w_mis) begin
                                r_state    <= ST_SEARCH;
                                r_good_cnt <= 8'd0;
                                r_sync_err <= 1'b1;
                            end else if (w_v_rise) begin
                                if (r_good_cnt + 8'd1 == GOOD_MAX) begin
                                    r_state       <= ST_LOCKED;
                                    r_good_cnt    <= 8'd0;
                                    r_err_cnt     <= 8'd0;
                                    r_locked      <= 1'b1;
                                    r_video       <= w_video_next;
                                    r_frame_start <= w_origin;
                                end else begin
                                    r_good_cnt <= r_good_cnt + 8'd1;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            r_video       <= w_video_next;
                            r_frame_start <= w_origin;
                            if (w_mis) begin
                                r_sync_err <= 1'b1;
                                if (r_err_cnt + 8'd1 == ERR_MAX) begin
                                    r_state       <= ST_SEARCH;
                                    r_err_cnt     <= 8'd0;
                                    r_locked      <= 1'b0;
                                    r_video       <= 1'b0;
                                    r_frame_start <= 1'b0;
                                end else begin
                                    r_err_cnt <= r_err_cnt + 8'd1;
                                end
                            end else if (w_pass) begin
                                r_err_cnt <= 8'd0;
                            end
                        end
                        default: begin
                            r_state  <= ST_SEARCH;
                            r_locked <= 1'b0;
                            r_video  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign pxl_x       = r_h_cnt;
    assign pxl_y       = r_v_cnt;
    assign video       = r_video;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign sync_err    = r_sync_err;

endmodule
